// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state enum, BCD width/limits and load clamp helper
package stopwatch_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;
  localparam logic [BCD_W-1:0] TENS_MAX = 4'd5;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  function automatic logic [BCD_W-1:0] clamp(input logic [BCD_W-1:0] v, input logic [BCD_W-1:0] lim);
    return v > lim ? lim : v;
  endfunction
endpackage

// File: rtl/bcd_time_counter_if.sv
// bcd_time_counter_if: control pulses, preset digits (master->slave); display digits, running, done (slave->master)
interface bcd_time_counter_if;
  import stopwatch_pkg::*;
  logic deciClk, up, start, stop, clear, load;
  logic [BCD_W-1:0] ld_mins, ld_tens, ld_ones, ld_tenths;
  logic [BCD_W-1:0] mins, tens, ones, tenths;
  logic running, done;
  modport master(output deciClk, up, start, stop, clear, load, ld_mins, ld_tens, ld_ones, ld_tenths,
                 input mins, tens, ones, tenths, running, done);
  modport slave(input deciClk, up, start, stop, clear, load, ld_mins, ld_tens, ld_ones, ld_tenths,
                output mins, tens, ones, tenths, running, done);
endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one up/down BCD digit step; value/enable/up/limit in, nxt value and carry/borrow out
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic [BCD_W-1:0] value,
  input  logic             enable,
  input  logic             up,
  input  logic [BCD_W-1:0] limit,
  output logic [BCD_W-1:0] nxt,
  output logic             carry
);
  logic at_end;
  always_comb begin
    at_end = up ? value == limit : value == '0;
    carry = enable & at_end;
    nxt = !enable ? value : at_end ? (up ? '0 : limit) : (up ? value + 1'b1 : value - 1'b1);
  end
endmodule

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: M:SS.t BCD up/down stopwatch counter with IDLE/RUN/PAUSED/DONE control; clk, async reset, bus (slave)
module bcd_time_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MINS = 9
) (
  input logic               clk,
  input logic               reset,
  bcd_time_counter_if.slave bus
);
  localparam logic [BCD_W-1:0] MINS_LIM = BCD_W'(MAX_MINS);
  localparam logic [3:0][BCD_W-1:0] TERM_UP = {MINS_LIM, TENS_MAX, DIGIT_MAX, DIGIT_MAX};
  state_t state_q, state_d;
  logic [3:0][BCD_W-1:0] d_q, d_d, nxt;
  logic [4:0] c;
  logic nxt_term, run_q, done_q;
  // With the chain always enabled, the final carry means every digit sits at its
  // end value for the current direction, i.e. the current value is the terminal.
  assign c[0] = 1'b1;
  for (genvar i = 0; i < 4; i++) begin : g_dig
    bcd_digit u_dig (
      .value(d_q[i]),
      .enable(c[i]),
      .up(bus.up),
      .limit(i == 3 ? MINS_LIM : i == 2 ? TENS_MAX : DIGIT_MAX),
      .nxt(nxt[i]),
      .carry(c[i+1])
    );
  end
  assign nxt_term = nxt == (bus.up ? TERM_UP : '0);
  always_comb begin
    state_d = state_q;
    d_d = d_q;
    if (bus.clear) begin
      d_d = '0;
      state_d = IDLE;
    end else if (bus.load && state_q != RUN) begin
      d_d = {clamp(bus.ld_mins, MINS_LIM), clamp(bus.ld_tens, TENS_MAX),
             clamp(bus.ld_ones, DIGIT_MAX), clamp(bus.ld_tenths, DIGIT_MAX)};
      state_d = IDLE;
    end else if (bus.stop && state_q == RUN) begin
      state_d = PAUSED;
    end else if (bus.start && state_q != RUN) begin
      state_d = c[4] ? DONE : RUN;
    end else if (bus.deciClk && state_q == RUN) begin
      // Already at the terminal (direction flipped mid-run): hold rather than wrap.
      d_d = c[4] ? d_q : nxt;
      state_d = c[4] || nxt_term ? DONE : RUN;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      d_q <= '0;
      run_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q <= d_d;
      run_q <= state_d == RUN;
      done_q <= state_d == DONE;
    end
  end
  assign bus.mins = d_q[3];
  assign bus.tens = d_q[2];
  assign bus.ones = d_q[1];
  assign bus.tenths = d_q[0];
  assign bus.running = run_q;
  assign bus.done = done_q;
endmodule
